// File: rtl/tone_seq_pkg.sv
// Shared types and default widths for the tone sequencer and its oscillator.
package tone_seq_pkg;
  localparam int unsigned STEP_W = 16;
  localparam int unsigned DUR_W  = 16;

  typedef enum logic {IDLE, PLAY} state_t;

  typedef struct packed {
    logic [STEP_W-1:0] step;
    logic [DUR_W-1:0]  dur;
  } entry_t;
endpackage

// File: rtl/tone_sequencer_if.sv
// Control/status bundle between the sequencer and the logic that programs it.
interface tone_sequencer_if #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned STEP_W = tone_seq_pkg::STEP_W,
  parameter int unsigned DUR_W  = tone_seq_pkg::DUR_W
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [STEP_W-1:0] wr_step;
  logic [DUR_W-1:0]  wr_dur;
  logic [ADDR_W-1:0] cfg_last;
  logic              loop_en;
  logic              start;
  logic              stop;
  logic [STEP_W-1:0] step_out;
  logic              osc_reset;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] cur_idx;

  modport master (
    output wr_en, wr_addr, wr_step, wr_dur, cfg_last, loop_en, start, stop,
    input  step_out, osc_reset, busy, done, cur_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_step, wr_dur, cfg_last, loop_en, start, stop,
    output step_out, osc_reset, busy, done, cur_idx
  );
endinterface

// File: rtl/tone_table.sv
// DEPTH-entry (step, duration) register array: synchronous write and clear, combinational read.
module tone_table #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned STEP_W = tone_seq_pkg::STEP_W,
  parameter int unsigned DUR_W  = tone_seq_pkg::DUR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [STEP_W-1:0] i_wr_step,
  input  logic [DUR_W-1:0]  i_wr_dur,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [STEP_W-1:0] o_rd_step,
  output logic [DUR_W-1:0]  o_rd_dur
);
  logic [STEP_W-1:0] r_step [DEPTH];
  logic [DUR_W-1:0]  r_dur  [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_step[i] <= '0;
        r_dur[i]  <= '0;
      end
    end else if (i_wr_en && (32'(i_wr_addr) < DEPTH)) begin
      r_step[i_wr_addr] <= i_wr_step;
      r_dur[i_wr_addr]  <= i_wr_dur;
    end
  end

  assign o_rd_step = r_step[i_rd_addr];
  assign o_rd_dur  = r_dur[i_rd_addr];
endmodule

// File: rtl/tone_sequencer.sv
// Steps a triangle oscillator through a programmed list of (step, duration) tones.
module tone_sequencer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned STEP_W = tone_seq_pkg::STEP_W,
  parameter int unsigned DUR_W  = tone_seq_pkg::DUR_W
) (
  input logic             clk,
  input logic             reset,
  tone_sequencer_if.slave bus
);
  import tone_seq_pkg::*;

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_last;
  logic [DUR_W-1:0]  r_cnt;
  logic [STEP_W-1:0] r_step;
  logic              r_osc;
  logic              r_busy;
  logic              r_done;

  logic [ADDR_W-1:0] w_cfg_last;
  logic              w_at_last;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [STEP_W-1:0] w_rd_step;
  logic [DUR_W-1:0]  w_rd_dur;

  assign w_cfg_last = (32'(bus.cfg_last) >= DEPTH) ? ADDR_W'(DEPTH - 1) : bus.cfg_last;
  assign w_at_last  = (r_idx == r_last);
  // Single read port: the next entry while mid-list, otherwise entry 0 (start or wrap).
  assign w_rd_addr  = (r_state == PLAY && !w_at_last) ? r_idx + ADDR_W'(1) : '0;

  tone_table #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .STEP_W (STEP_W),
    .DUR_W  (DUR_W)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (bus.wr_en),
    .i_wr_addr (bus.wr_addr),
    .i_wr_step (bus.wr_step),
    .i_wr_dur  (bus.wr_dur),
    .i_rd_addr (w_rd_addr),
    .o_rd_step (w_rd_step),
    .o_rd_dur  (w_rd_dur)
  );

  // A loaded count of 0 wraps through all ones, giving 2^DUR_W cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_last  <= '0;
      r_cnt   <= '0;
      r_step  <= '0;
      r_osc   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_osc  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            r_state <= PLAY;
            r_idx   <= '0;
            r_last  <= w_cfg_last;
            r_step  <= w_rd_step;
            r_cnt   <= w_rd_dur;
            r_osc   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        PLAY: begin
          if (bus.stop) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == DUR_W'(1)) begin
            if (!w_at_last || bus.loop_en) begin
              r_idx  <= w_rd_addr;
              r_step <= w_rd_step;
              r_cnt  <= w_rd_dur;
            end else begin
              r_state <= IDLE;
              r_step  <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - DUR_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.step_out  = r_step;
  assign bus.osc_reset = r_osc;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.cur_idx   = r_idx;
endmodule

// File: tb/tb_tone_sequencer.sv
// Drives a 16-bit-duration and a 4-bit-duration sequencer in lockstep against a tone-list model.
module tb_tone_sequencer;
  localparam int unsigned DEPTH = 16;

  typedef struct packed {
    logic [15:0] step;
    logic        osc;
    logic        busy;
    logic        done;
    logic [3:0]  idx;
    logic        idx_chk;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        s_wr_en, s_loop, s_start, s_stop;
  logic [3:0]  s_wr_addr, s_cfg_last;
  logic [15:0] s_wr_step, s_wr_dur;

  tone_sequencer_if #(.DEPTH(DEPTH), .STEP_W(16), .DUR_W(16)) if_a ();
  tone_sequencer_if #(.DEPTH(DEPTH), .STEP_W(16), .DUR_W(4))  if_b ();

  assign if_a.wr_en = s_wr_en;     assign if_b.wr_en = s_wr_en;
  assign if_a.wr_addr = s_wr_addr; assign if_b.wr_addr = s_wr_addr;
  assign if_a.wr_step = s_wr_step; assign if_b.wr_step = s_wr_step;
  assign if_a.wr_dur = s_wr_dur;   assign if_b.wr_dur = s_wr_dur[3:0];
  assign if_a.cfg_last = s_cfg_last; assign if_b.cfg_last = s_cfg_last;
  assign if_a.loop_en = s_loop;    assign if_b.loop_en = s_loop;
  assign if_a.start = s_start;     assign if_b.start = s_start;
  assign if_a.stop = s_stop;       assign if_b.stop = s_stop;

  tone_sequencer #(.DEPTH(DEPTH), .STEP_W(16), .DUR_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .bus(if_a));
  tone_sequencer #(.DEPTH(DEPTH), .STEP_W(16), .DUR_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .bus(if_b));

  // Reference model: a tone list plus "which entry, how many cycles left".
  int unsigned m_step [2][DEPTH];
  int unsigned m_dur  [2][DEPTH];
  bit          m_on   [2];
  int unsigned m_idx  [2];
  int unsigned m_rem  [2];
  int unsigned m_last [2];
  int unsigned m_tone [2];

  obs_t exp_a[$];
  obs_t exp_b[$];
  int   checks = 0;
  int   failures = 0;

  function automatic int unsigned tone_len(int k, int unsigned d);
    int unsigned w = (k == 0) ? 16 : 4;
    return (d == 0) ? (32'd1 << w) : d;
  endfunction

  task automatic enter(int k, int unsigned i);
    m_idx[k]  = i;
    m_tone[k] = m_step[k][i];
    m_rem[k]  = tone_len(k, m_dur[k][i]);
  endtask

  task automatic model_edge(int k);
    obs_t e;
    e = '0;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_step[k][i] = 0;
        m_dur[k][i]  = 0;
      end
      m_on[k] = 0; m_idx[k] = 0; m_last[k] = 0;
      e.idx_chk = 1'b1;
    end else begin
      if (!m_on[k]) begin
        if (s_start && !s_stop) begin
          m_on[k] = 1;
          m_last[k] = s_cfg_last;
          enter(k, 0);
          e.osc = 1'b1;
        end
      end else if (s_stop) begin
        m_on[k] = 0;
      end else if (m_rem[k] == 1) begin
        if (m_idx[k] != m_last[k]) enter(k, m_idx[k] + 1);
        else if (s_loop) enter(k, 0);
        else begin
          m_on[k] = 0;
          e.done = 1'b1;
        end
      end else begin
        m_rem[k]--;
      end
      if (s_wr_en) begin
        m_step[k][s_wr_addr] = s_wr_step;
        m_dur[k][s_wr_addr]  = (k == 0) ? s_wr_dur : (s_wr_dur & 16'hF);
      end
    end
    e.busy = m_on[k];
    e.step = m_on[k] ? m_tone[k][15:0] : 16'd0;
    if (m_on[k]) begin
      e.idx = m_idx[k][3:0];
      e.idx_chk = 1'b1;
    end
    if (k == 0) exp_a.push_back(e);
    else exp_b.push_back(e);
  endtask

  task automatic cyc();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    s_wr_en = 0; s_start = 0; s_stop = 0;
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic wr(int a, int st, int d);
    s_wr_en = 1; s_wr_addr = 4'(a); s_wr_step = 16'(st); s_wr_dur = 16'(d);
    cyc();
  endtask

  task automatic compare(string name, obs_t act, obs_t e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s t=%0t: got step=%0d osc=%b busy=%b done=%b idx=%0d, want step=%0d osc=%b busy=%b done=%b idx=%0d",
               name, $time, act.step, act.osc, act.busy, act.done, act.idx,
               e.step, e.osc, e.busy, e.done, e.idx);
    end
  endtask

  always @(negedge clk) begin
    obs_t e, act;
    if (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      act = {if_a.step_out, if_a.osc_reset, if_a.busy, if_a.done,
             e.idx_chk ? if_a.cur_idx : e.idx, e.idx_chk};
      compare("dur16", act, e);
    end
    if (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      act = {if_b.step_out, if_b.osc_reset, if_b.busy, if_b.done,
             e.idx_chk ? if_b.cur_idx : e.idx, e.idx_chk};
      compare("dur4", act, e);
    end
  end

  initial begin
    s_wr_en = 0; s_wr_addr = 0; s_wr_step = 0; s_wr_dur = 0;
    s_cfg_last = 0; s_loop = 0; s_start = 0; s_stop = 0;
    reset = 1;
    run(2);
    reset = 0;
    run(2);

    // Plain two-entry list, then looping and a graceful loop exit.
    wr(0, 100, 3); wr(1, 200, 2);
    s_cfg_last = 1; s_loop = 0; s_start = 1; cyc(); run(8);
    s_loop = 1; s_start = 1; cyc(); run(7);
    s_loop = 0; run(10);

    // Stop on the second cycle of entry 0; start+stop together in idle.
    s_start = 1; cyc(); cyc();
    s_stop = 1; cyc(); run(3);
    s_start = 1; s_stop = 1; cyc(); run(3);

    // Rewrites during playback, and a write at the very edge of the load.
    wr(0, 100, 4);
    s_start = 1; cyc();
    wr(0, 999, 4); wr(1, 555, 1); run(6);
    s_start = 1; s_wr_en = 1; s_wr_addr = 0; s_wr_step = 777; s_wr_dur = 2;
    cyc(); run(8);

    // Randomised programming and control.
    for (int n = 0; n < 1500; n++) begin
      s_wr_en    = ($urandom_range(0, 2) == 0);
      s_wr_addr  = 4'($urandom_range(0, 15));
      s_wr_step  = 16'($urandom);
      s_wr_dur   = 16'($urandom_range(1, 6));
      s_cfg_last = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) s_loop = ~s_loop;
      s_start = ($urandom_range(0, 9) == 0);
      s_stop  = ($urandom_range(0, 39) == 0);
      reset   = ($urandom_range(0, 299) == 0);
      cyc();
      reset = 0;
    end
    s_loop = 0; s_stop = 1; cyc(); run(2);

    // dur=0 means full counter range; re-start mid-play is ignored.
    wr(0, 1234, 0);
    s_cfg_last = 0; s_start = 1; cyc(); run(5);
    s_start = 1; cyc(); run(30);

    // Reset mid-play clears everything; the cleared entry plays step 0 for 2^DUR_W cycles.
    reset = 1; cyc(); reset = 0; run(2);
    s_cfg_last = 0; s_start = 1; cyc(); run(65540);

    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
Plays a programmed list of tones on the triangle oscillator. Each table entry is a (step, duration) pair. The block drives the oscillator's 16-bit phase step and sequences through entries for a fixed number of clk cycles each, optionally looping. It issues a phase-restart pulse at the start of playback and reports busy and done status to the control logic.

Parameters:
DEPTH, 16, number of table entries (power of two, 2..256)
ADDR_W, $clog2(DEPTH), entry index width (derived, not overridden)
STEP_W, 16, phase step width (matches oscillator step input)
DUR_W, 16, per-entry duration counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  table write strobe
wr_addr  in  ADDR_W  table write index
wr_step  in  STEP_W  step value to write
wr_dur  in  DUR_W  duration to write, in clk cycles
cfg_last  in  ADDR_W  index of last entry to play; latched at start
loop_en  in  1  wrap to entry 0 after the last entry; sampled live
start  in  1  begin playback from entry 0 (single-cycle strobe)
stop  in  1  abort playback
step_out  out  STEP_W  phase step to oscillator; 0 when not playing
osc_reset  out  1  one-cycle pulse to restart oscillator phase
busy  out  1  high while in PLAY
done  out  1  one-cycle pulse on normal completion
cur_idx  out  ADDR_W  index of the entry currently playing

Behaviour:
- Reset (clk edge with reset=1):
  - State goes to IDLE.
  - step_out=0, osc_reset=0, busy=0, done=0, cur_idx=0, latched last index=0.
  - Every table entry is cleared to (0,0).
- Table:
  - Register array with combinational read.
  - A write with wr_en=1 takes effect at the clk edge and is legal in any state.
  - A write to the currently playing entry does not alter the tone in progress, because step and count are latched on entry load.
  - A write at the same edge the entry is loaded: the old value is used.
- States: IDLE and PLAY.
- IDLE:
  - start=1 and stop=0 at edge t: at t+1 the state is PLAY, cur_idx=0, step_out=table[0].step, the counter is loaded from table[0].dur, busy=1, and osc_reset=1 for that single cycle.
  - start and stop both high: stop wins and the state stays IDLE.
- PLAY:
  - Each cycle the counter decrements.
  - An entry lasts exactly dur cycles. dur=0 is interpreted as 2^DUR_W cycles.
  - On the final cycle of an entry (count==1), the next edge advances:
    - cur_idx != latched last: idx+1, with step and count loaded from the table. No gap cycle occurs and step_out changes exactly on that edge.
    - cur_idx == last and loop_en=1: idx=0 and the table[0] entry is loaded. No osc_reset is issued on a loop wrap.
    - cur_idx == last and loop_en=0: go to IDLE with step_out=0, busy=0, and done=1 for one cycle.
- stop=1 in PLAY: next edge goes to IDLE with step_out=0 and busy=0. done is not pulsed. stop takes priority over an advance in the same cycle.
- start in PLAY is ignored and does not restart playback.
- cfg_last is latched only on start, so changing it mid-playback has no effect. If cfg_last >= DEPTH (only possible when DEPTH is not a power of two), it is clamped to DEPTH-1.
- Clearing loop_en mid-playback ends playback gracefully after the next pass through the last entry.
- Outputs are all registered. Latency from start to the first tone is 1 cycle.
- reset asserted mid-PLAY aborts immediately to reset values. No done pulse is issued.

Decomposition:
- Shared package tone_seq_pkg holds:
  - the state enum (IDLE, PLAY);
  - the entry type {step[STEP_W], dur[DUR_W]};
  - default width constants STEP_W=16 and DUR_W=16, shared with the oscillator's step width.
- One natural sub-module: tone_table, the DEPTH-entry register array with a synchronous write, combinational read and synchronous clear.
- The FSM, counter and output registers stay in the top module.

Test Plan:
1. Reset, then write entries 0:(100,3), 1:(200,2), cfg_last=1, loop_en=0, pulse start → step_out=100 for 3 cycles, then 200 for 2 cycles, then 0. osc_reset is high on cycle 1 only. done pulses exactly once, on the cycle step_out returns to 0. busy is high for 5 cycles.
2. Same table with loop_en=1 → sequence 100,100,100,200,200,100,... with no osc_reset on the wrap. Clear loop_en during the second pass → playback ends after entry 1 with a done pulse.
3. Assert stop on the 2nd cycle of entry 0 → step_out=0 and busy=0 next cycle, no done pulse. start and stop together in IDLE → stays IDLE.
4. During entry 0 of (100,4), write entry 0 to (999,4) and entry 1 to (555,1) → the current tone remains 100 for 4 cycles, then 555 for 1 cycle. A later restart plays 999.
5. Write entry 0 with dur=0 (using DUR_W=4 override), cfg_last=0, start → step_out held for 16 cycles, then a done pulse. start re-asserted mid-play is ignored.
6. Assert reset mid-PLAY → next cycle all outputs are at reset values and the table reads (0,0). A following start with cfg_last=0 plays step 0 for 65536 cycles (default DUR_W).
